data_mem_responder: RTL

Memory-side responder for the core's data port. It accepts the core's word-wide byte-lane requests (mem_addr, mem_data_in[0:3], mem_write_en) and a read strobe, and stores data in a big-endian, byte-addressed array. It returns read data on mem_data_out[0:3] after a configurable latency. After reset it zero-fills the whole array with a sweep state machine, and it signals readiness and errors back to the core.

---
 rtl/data_mem_responder_if.sv | 22 ++
 rtl/data_mem_responder.sv | 117 +++++++++++
 2 files changed

// File: rtl/data_mem_responder_if.sv
// Core <-> data memory handshake bundle. The core drives the request side,
// and the responder drives the read data, ready and error returns.
interface data_mem_responder_if;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data_in  [0:3];
  logic        mem_write_en;
  logic        mem_read_en;
  logic        halted;
  logic [7:0]  mem_data_out [0:3];
  logic        mem_ready;
  logic        mem_error;

  modport master (
    output mem_addr, mem_data_in, mem_write_en, mem_read_en, halted,
    input  mem_data_out, mem_ready, mem_error
  );

  modport slave (
    input  mem_addr, mem_data_in, mem_write_en, mem_read_en, halted,
    output mem_data_out, mem_ready, mem_error
  );
endinterface

// File: rtl/data_mem_responder.sv
// Big-endian byte-addressed data memory with a zero-fill sweep after reset,
// configurable read latency (1..4), and a sticky error flag for bad requests.
module data_mem_responder #(
  parameter int ADDR_BITS    = 12,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_b,
  data_mem_responder_if.slave  bus
);
  localparam int         WBITS   = ADDR_BITS - 2;
  localparam int         WORDS   = 1 << WBITS;
  localparam logic [2:0] RD_LOAD = 3'(READ_LATENCY - 1);

  typedef enum logic [1:0] {INIT, IDLE, BUSY} state_e;

  state_e            state, state_nxt;
  logic [WBITS-1:0]  sweep_ptr, sweep_nxt;
  logic [2:0]        rd_cnt, rd_cnt_nxt;
  logic [31:0]       rd_word, rd_word_nxt;
  logic [31:0]       out_q, out_nxt;
  logic              err_q, err_nxt;
  logic              ready_q;

  logic [31:0]       mem [WORDS];
  logic              mem_we;
  logic [WBITS-1:0]  mem_waddr;
  logic [31:0]       mem_wdata;

  logic [WBITS-1:0]  widx;
  logic [31:0]       wdata;
  logic              addr_bad;

  assign widx     = bus.mem_addr[ADDR_BITS-1:2];
  assign wdata    = {bus.mem_data_in[0], bus.mem_data_in[1],
                     bus.mem_data_in[2], bus.mem_data_in[3]};
  assign addr_bad = (bus.mem_addr[1:0] != 2'b00) ||
                    ((bus.mem_addr >> ADDR_BITS) != 32'd0);

  always_comb begin
    state_nxt   = state;
    sweep_nxt   = sweep_ptr;
    rd_cnt_nxt  = rd_cnt;
    rd_word_nxt = rd_word;
    out_nxt     = out_q;
    err_nxt     = err_q;
    mem_we      = 1'b0;
    mem_waddr   = widx;
    mem_wdata   = wdata;
    unique case (state)
      INIT: begin
        mem_we    = 1'b1;
        mem_waddr = sweep_ptr;
        mem_wdata = '0;
        sweep_nxt = sweep_ptr + 1'b1;
        if (&sweep_ptr) state_nxt = IDLE;
      end
      IDLE: begin
        // A write wins over a simultaneous read; the dropped read is an error.
        if (bus.mem_write_en) begin
          if (addr_bad || bus.mem_read_en) err_nxt = 1'b1;
          mem_we = !addr_bad && !bus.halted;
        end else if (bus.mem_read_en) begin
          if (addr_bad) begin
            err_nxt = 1'b1;
          end else if (READ_LATENCY == 1) begin
            out_nxt = mem[widx];
          end else begin
            rd_word_nxt = mem[widx];
            rd_cnt_nxt  = RD_LOAD;
            state_nxt   = BUSY;
          end
        end
      end
      BUSY: begin
        rd_cnt_nxt = rd_cnt - 3'd1;
        if (rd_cnt == 3'd1) begin
          out_nxt   = rd_word;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= INIT;
      sweep_ptr <= '0;
      rd_cnt    <= '0;
      rd_word   <= '0;
      out_q     <= '0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      sweep_ptr <= sweep_nxt;
      rd_cnt    <= rd_cnt_nxt;
      rd_word   <= rd_word_nxt;
      out_q     <= out_nxt;
      err_q     <= err_nxt;
      ready_q   <= (state_nxt == IDLE);
    end
  end

  // Array has no reset; the sweep clears it once reset is released.
  always_ff @(posedge clk) begin
    if (mem_we && rst_b) mem[mem_waddr] <= mem_wdata;
  end

  assign bus.mem_ready = ready_q;
  assign bus.mem_error = err_q;

  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign bus.mem_data_out[k] = out_q[31-8*k -: 8];
  end
endmodule
